// File: rtl/pwm_multi_pkg.sv
// pwm_multi_pkg: shared types and default sizing for the multi-channel PWM.
// Register-bank field widths can reference the PWM_*_DEF localparams.
package pwm_multi_pkg;

    localparam int unsigned PWM_CH_DEF      = 4;
    localparam int unsigned PWM_W_DEF       = 8;
    localparam int unsigned PWM_PRESC_W_DEF = 4;

    // Widest supported counter; the comparator works at this width.
    localparam int unsigned PWM_CMP_W = 16;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_t;

    // Counting down, the compare includes equality so the high time is
    // exactly 2*duty ticks and symmetric about cnt=0.
    function automatic logic pwm_compare(
        input pwm_dir_t               dir,
        input logic [PWM_CMP_W-1:0]   cnt,
        input logic [PWM_CMP_W-1:0]   duty
    );
        return (dir == DIR_UP) ? (cnt < duty) : (cnt <= duty);
    endfunction

endpackage

// File: rtl/pwm_multi_timebase.sv
// pwm_multi_timebase: prescaler, period counter and direction shared by all
// PWM channels. Latches the waveform mode at each period boundary.
//   clk, resetb   clock, asynchronous active-low reset
//   ena           run enable; low holds the counter at the period start
//   mode          requested mode (0 edge, 1 center), taken at boundaries
//   prescale      counter advances once every prescale+1 clk
//   cnt, dir      current counter state
//   run           counter is running (first enabled clk has passed)
//   boundary      a new period starts on this clk edge
module pwm_multi_timebase
    import pwm_multi_pkg::*;
#(
    parameter int unsigned W       = PWM_W_DEF,
    parameter int unsigned PRESC_W = PWM_PRESC_W_DEF
) (
    input  logic               clk,
    input  logic               resetb,
    input  logic               ena,
    input  logic               mode,
    input  logic [PRESC_W-1:0] prescale,
    output logic [W-1:0]       cnt,
    output pwm_dir_t           dir,
    output logic               run,
    output logic               boundary
);

    localparam logic [W-1:0] CNT_MAX  = '1;
    localparam logic [W-1:0] CNT_LAST = CNT_MAX - 1'b1;

    logic [PRESC_W-1:0] pcnt, pcnt_n;
    logic [W-1:0]       cnt_n;
    pwm_dir_t           dir_n;
    pwm_mode_t          mode_act, mode_n;
    logic               run_n;
    logic               tick;

    // ">=" rather than "==": a live prescale reduction below pcnt must not
    // stall the counter for a full wrap of pcnt.
    assign tick = ena && run && (pcnt >= prescale);

    always_comb begin
        pcnt_n   = pcnt;
        cnt_n    = cnt;
        dir_n    = dir;
        mode_n   = mode_act;
        run_n    = run;
        boundary = 1'b0;
        if (!ena) begin
            pcnt_n = '0;
            cnt_n  = '0;
            dir_n  = DIR_UP;
            mode_n = pwm_mode_t'(mode);
            run_n  = 1'b0;
        end else if (!run) begin
            // First enabled clk: hold cnt at 0 and open a period.
            pcnt_n   = '0;
            cnt_n    = '0;
            dir_n    = DIR_UP;
            run_n    = 1'b1;
            boundary = 1'b1;
            mode_n   = pwm_mode_t'(mode);
        end else if (tick) begin
            pcnt_n = '0;
            if (mode_act == PWM_EDGE) begin
                if (cnt == CNT_LAST) begin
                    cnt_n    = '0;
                    boundary = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end else if (dir == DIR_UP) begin
                if (cnt == CNT_LAST) begin
                    cnt_n = CNT_MAX;
                    dir_n = DIR_DOWN;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end else begin
                if (cnt == W'(1)) begin
                    cnt_n    = '0;
                    dir_n    = DIR_UP;
                    boundary = 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            if (boundary) begin
                mode_n = pwm_mode_t'(mode);
            end
        end else begin
            pcnt_n = pcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            pcnt     <= '0;
            cnt      <= '0;
            dir      <= DIR_UP;
            mode_act <= PWM_EDGE;
            run      <= 1'b0;
        end else begin
            pcnt     <= pcnt_n;
            cnt      <= cnt_n;
            dir      <= dir_n;
            mode_act <= mode_n;
            run      <= run_n;
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: CH-channel PWM generator with prescaler, edge/center-aligned
// mode and double-buffered duty updates applied at period boundaries.
//   clk, resetb    clock, asynchronous active-low reset
//   ena            run enable; low idles outputs and applies staged values
//   mode           0 edge-aligned, 1 center-aligned (taken at boundaries)
//   prescale       counter advances once every prescale+1 clk
//   duty           packed duty words, channel k = duty[k*W +: W]
//   duty_load      1-clk strobe capturing duty into staging registers
//   load_pending   staged duty not yet applied
//   period_start   1-clk pulse following each period boundary
//   pwm_out        registered PWM outputs
// Optional build macro PWM_POLARITY_EN adds input pol[CH-1:0]; each output
// is then XORed with pol, so the idle level equals pol.
module pwm_multi
    import pwm_multi_pkg::*;
#(
    parameter int unsigned CH      = PWM_CH_DEF,
    parameter int unsigned W       = PWM_W_DEF,
    parameter int unsigned PRESC_W = PWM_PRESC_W_DEF
) (
    input  logic               clk,
    input  logic               resetb,
    input  logic               ena,
    input  logic               mode,
    input  logic [PRESC_W-1:0] prescale,
    input  logic [CH*W-1:0]    duty,
    input  logic               duty_load,
`ifdef PWM_POLARITY_EN
    input  logic [CH-1:0]      pol,
`endif
    output logic               load_pending,
    output logic               period_start,
    output logic [CH-1:0]      pwm_out
);

    logic [W-1:0]  cnt;
    pwm_dir_t      dir;
    logic          run;
    logic          boundary;
    logic          apply;
    logic [CH-1:0] cmp;
    logic [CH-1:0] pwm_next;

    pwm_multi_timebase #(
        .W       (W),
        .PRESC_W (PRESC_W)
    ) u_timebase (
        .clk      (clk),
        .resetb   (resetb),
        .ena      (ena),
        .mode     (mode),
        .prescale (prescale),
        .cnt      (cnt),
        .dir      (dir),
        .run      (run),
        .boundary (boundary)
    );

    // Staging is copied to the active duty every idle clk, or at a
    // boundary when a load is pending. A load on that same clk lands in
    // staging after the copy, so it waits for the following boundary.
    assign apply = !ena || (boundary && load_pending);

    genvar k;
    generate
        for (k = 0; k < CH; k++) begin : g_ch
            logic [W-1:0] staging;
            logic [W-1:0] duty_act;

            always_ff @(posedge clk or negedge resetb) begin
                if (!resetb) begin
                    staging  <= '0;
                    duty_act <= '0;
                end else begin
                    if (duty_load) begin
                        staging <= duty[k*W +: W];
                    end
                    if (apply) begin
                        duty_act <= staging;
                    end
                end
            end

            // run gates the start clk, whose counter state precedes the period.
            assign cmp[k] = run && pwm_compare(dir, PWM_CMP_W'(cnt), PWM_CMP_W'(duty_act));
        end
    endgenerate

`ifdef PWM_POLARITY_EN
    assign pwm_next = (ena ? cmp : '0) ^ pol;
`else
    assign pwm_next = ena ? cmp : '0;
`endif

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            load_pending <= 1'b0;
            period_start <= 1'b0;
            pwm_out      <= '0;
        end else begin
            if (duty_load) begin
                load_pending <= 1'b1;
            end else if (apply) begin
                load_pending <= 1'b0;
            end
            period_start <= boundary;
            pwm_out      <= pwm_next;
        end
    end

endmodule
